// File: rtl/tqv_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tqv_bus_pkg
//  Description : Size codes, initiator FSM states and read-data masking for
//                the TinyQV peripheral data bus.
//  Revision    : 1.0  initial release
// ============================================================================
package tqv_bus_pkg;

    localparam logic [1:0] SZ_8    = 2'b00;
    localparam logic [1:0] SZ_16   = 2'b01;
    localparam logic [1:0] SZ_32   = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Zero-extend the responder's data to the width of the access.
    function automatic logic [31:0] mask_by_size(input logic [31:0] data,
                                                 input logic [1:0]  size);
        logic [31:0] result;
        case (size)
            SZ_8:    result = {24'b0, data[7:0]};
            SZ_16:   result = {16'b0, data[15:0]};
            default: result = data;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tqv_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tqv_timeout_counter
//  Description : Counts stalled request cycles; flags the cycle whose
//                increment would reach TIMEOUT_CYCLES.
//  Revision    : 1.0  initial release
// ============================================================================
module tqv_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/tqv_periph_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tqv_periph_initiator
//  Description : Single-outstanding command/response initiator driving the
//                TinyQV peripheral data bus, with request timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module tqv_periph_initiator
    import tqv_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready
);

    state_t      r_state,     w_state;
    logic        r_cmd_ready, w_cmd_ready;
    logic        r_rsp_valid, w_rsp_valid;
    logic [31:0] r_rsp_rdata, w_rsp_rdata;
    logic        r_rsp_err,   w_rsp_err;
    logic [5:0]  r_address,   w_address;
    logic [31:0] r_data_in,   w_data_in;
    logic [1:0]  r_write_n,   w_write_n;
    logic [1:0]  r_read_n,    w_read_n;
    logic        w_cnt_clear, w_cnt_enable, w_expired;

    tqv_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_enable),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_address   <= '0;
            r_data_in   <= '0;
            r_write_n   <= SZ_NONE;
            r_read_n    <= SZ_NONE;
        end else begin
            r_state     <= w_state;
            r_cmd_ready <= w_cmd_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_address   <= w_address;
            r_data_in   <= w_data_in;
            r_write_n   <= w_write_n;
            r_read_n    <= w_read_n;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_cmd_ready  = r_cmd_ready;
        w_rsp_valid  = r_rsp_valid;
        w_rsp_rdata  = r_rsp_rdata;
        w_rsp_err    = r_rsp_err;
        w_address    = r_address;
        w_data_in    = r_data_in;
        w_write_n    = r_write_n;
        w_read_n     = r_read_n;
        w_cnt_clear  = 1'b0;
        w_cnt_enable = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_cmd_ready = 1'b0;
                    if (cmd_size != SZ_NONE) begin
                        w_address   = cmd_addr;
                        w_data_in   = cmd_write ? cmd_wdata : 32'h0;
                        w_write_n   = cmd_write ? cmd_size : SZ_NONE;
                        w_read_n    = cmd_write ? SZ_NONE : cmd_size;
                        w_cnt_clear = 1'b1;
                        w_state     = ST_REQ;
                    end else begin
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                        w_rsp_rdata = '0;
                        w_state     = ST_RSP;
                    end
                end
            end
            ST_REQ: begin
                // A completion on the expiry edge takes priority over timeout.
                if (data_ready) begin
                    w_rsp_rdata = (r_read_n != SZ_NONE) ? mask_by_size(data_out, r_read_n) : 32'h0;
                    w_rsp_err   = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_write_n   = SZ_NONE;
                    w_read_n    = SZ_NONE;
                    w_state     = ST_RSP;
                end else begin
                    w_cnt_enable = 1'b1;
                    if (w_expired) begin
                        w_rsp_rdata = '0;
                        w_rsp_err   = 1'b1;
                        w_rsp_valid = 1'b1;
                        w_write_n   = SZ_NONE;
                        w_read_n    = SZ_NONE;
                        w_state     = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                    w_state     = ST_IDLE;
                end
            end
            default: begin
                w_state     = ST_IDLE;
                w_cmd_ready = 1'b1;
                w_rsp_valid = 1'b0;
                w_write_n   = SZ_NONE;
                w_read_n    = SZ_NONE;
            end
        endcase
    end

    assign cmd_ready    = r_cmd_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign address      = r_address;
    assign data_in      = r_data_in;
    assign data_write_n = r_write_n;
    assign data_read_n  = r_read_n;

endmodule
`default_nettype wire

// File: doc/tqv_periph_initiator.md
Name: tqv_periph_initiator

Overview:
- Bus initiator for the TinyQV peripheral data interface: the requesting end that peripheral responders sit behind.
- Accepts one command at a time on a valid/ready port and drives address, write data and the read/write size codes.
- Waits for data_ready, then returns read data or a write acknowledge on a valid/ready response port.
- Used by the debug/host bridge and by peripheral test benches to exercise responders without the CPU core.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a request stays asserted without data_ready before it is aborted with an error; must be at least 1.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid and ready are both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal
- cmd_addr  in  6  peripheral address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid and ready are both high
- rsp_rdata  out  32  read data, zero-extended to the access size; 0 for writes and errors
- rsp_err  out  1  1 = timeout or illegal size
- address  out  6  to the responder
- data_in  out  32  to the responder (write data)
- data_write_n  out  2  11 = idle, otherwise the size code
- data_read_n  out  2  11 = idle, otherwise the size code
- data_out  in  32  from the responder (read data)
- data_ready  in  1  from the responder

Behaviour:
- All outputs are registered.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, address=0, data_in=0, data_write_n=11, data_read_n=11, timeout count=0.
- Reset is asynchronous and valid at any time. Asserting it mid-transaction returns the block to IDLE and drops any bus request immediately.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - cmd_ready=1.
  - On handshake with cmd_size != 11: latch address and data_in (data_in = cmd_wdata for writes, 0 for reads); drive the size code onto data_write_n or data_read_n (the other stays 11); clear the counter; go to REQ.
  - So the request is visible the cycle after acceptance.
  - On handshake with cmd_size == 11: no bus activity; go to RSP with rsp_err=1, rsp_rdata=0.
- REQ:
  - cmd_ready=0. The request stays held and stable every cycle.
  - Each cycle, data_ready is sampled:
    - data_ready=1: at that edge, both size outputs return to 11; rsp_valid=1; rsp_err=0; go to RSP.
    - Read data on a completing edge: rsp_rdata = data_out masked by size (8-bit: bits 7:0, 16-bit: bits 15:0, 32-bit: all), upper bits 0.
    - Write data on a completing edge: rsp_rdata = 0.
    - data_ready=0: counter increments. When the counter reaches TIMEOUT_CYCLES, drop the request, set rsp_err=1, rsp_rdata=0, go to RSP.
  - A responder with data_ready tied high completes in exactly one request cycle.
  - Command-to-response latency with zero responder wait: 2 cycles (accept edge, then complete edge).
- RSP:
  - rsp_valid held with stable data until rsp_ready is high, then rsp_valid=0 and go to IDLE.
  - cmd_ready rises in the same edge that consumes the response, so there is no back-to-back overlap.
  - rsp_ready is ignored while rsp_valid=0.
- A data_ready that arrives on the same edge the counter reaches TIMEOUT_CYCLES counts as success; data_ready wins.
- Address and data_in hold their last values while idle.
- data_out and data_ready are ignored outside REQ.

Decomposition:
- Shared package tqv_bus_pkg holds:
  - size codes SZ_8=2'b00, SZ_16=2'b01, SZ_32=2'b10, SZ_NONE=2'b11;
  - FSM state enum;
  - a function that masks read data by size.
- One natural sub-module: tqv_timeout_counter (clear, enable, expired flag, parameterised by TIMEOUT_CYCLES and CNT_W).

Test Plan:
- Read with data_ready tied 1: size=10, addr=0x05, data_out=0xDEADBEEF. Expect data_read_n=10 for exactly 1 cycle, address=0x05, rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
- Write with 3 wait cycles: size=00, wdata=0x12345678, data_ready rising on the 4th request cycle. Expect data_write_n=00 and data_in=0x12345678 stable for 4 cycles, data_read_n=11 throughout, rsp_rdata=0, rsp_err=0.
- Read-size masking: size=01, data_out=0xAABBCCDD gives rsp_rdata=0x0000CCDD. Size=00 gives 0x000000DD.
- Timeout with TIMEOUT_CYCLES=4 and data_ready=0: request held 4 cycles then dropped to 11; rsp_err=1, rsp_rdata=0. Repeat with data_ready=1 on the 4th cycle: rsp_err=0.
- Illegal size=11: both size outputs never leave 11; rsp_valid=1 and rsp_err=1 the cycle after accept.
- Backpressure and reset: hold rsp_ready=0 for 5 cycles; rsp_valid and rsp_rdata stay stable and cmd_ready=0. Then assert rst mid-REQ: size outputs return to 11, cmd_ready=1, rsp_valid=0 without waiting for a clock edge.
